// File: rtl/rca.sv
// Registered ripple-carry adder: {cout, s} = a + b + cin through a chain of
// full-adder cells, with a signed-overflow flag, all registered with 1-cycle latency.
module rca #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    // Valid semantics: an operation is accepted on every rising edge where
    // in_valid=1 (no backpressure); out_valid is high for exactly the cycle
    // after each accepted operation and s/cout/ovf hold otherwise.

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic             ovf_next;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic p;
        assign p            = a[i] ^ b[i];
        assign sum[i]       = p ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (p & carry[i]);
    end

    // Carry into the MSB vs. carry out of it; for WIDTH=1 the former is cin.
    assign ovf_next = carry[WIDTH - 1] ^ carry[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s    <= sum;
                cout <= carry[WIDTH];
                ovf  <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_rca.sv
// Self-checking bench for rca (WIDTH=4): directed vectors, hold, reset cases,
// exhaustive sweep and random traffic against an arithmetic reference model.
module tb_rca;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             in_valid;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             out_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Expected results packed as {ovf, cout, s}
    logic [WIDTH+1:0] exp_q[$];
    logic [WIDTH+1:0] held;
    logic             exp_v;
    logic             cap;

    rca #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain unsigned and signed integer sums.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic ci);
        int u;
        int sx;
        int sy;
        int sg;
        logic [WIDTH+1:0] r;
        u  = int'(x) + int'(y) + int'(ci);
        sx = (int'(x) >= 8) ? int'(x) - 16 : int'(x);
        sy = (int'(y) >= 8) ? int'(y) - 16 : int'(y);
        sg = sx + sy + int'(ci);
        r[WIDTH-1:0] = u[WIDTH-1:0];
        r[WIDTH]     = u[WIDTH];
        r[WIDTH+1]   = (sg > 7) || (sg < -8);
        return r;
    endfunction

    // scoreboard: predicts every cycle from the inputs seen at the edge
    always @(posedge clk) begin
        cap = 1'b0;
        if (rst) begin
            exp_q.delete();
            held  = '0;
            exp_v = 1'b0;
        end else if (in_valid) begin
            exp_q.push_back(model(a, b, cin));
            exp_v = 1'b1;
            cap   = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(exp_v));
        if (cap) held = exp_q.pop_front();
        check("result", 32'({ovf, cout, s}), 32'(held));
    end

    // driver tasks
    task automatic drive(input logic r, input logic v, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input logic ci);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a        = x;
        b        = y;
        cin      = ci;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic directed(input string tag, input logic [WIDTH-1:0] x,
                            input logic [WIDTH-1:0] y, input logic ci,
                            input logic [WIDTH+1:0] exp);
        drive(1'b0, 1'b1, x, y, ci);
        step();
        check(tag, 32'({ovf, cout, s}), 32'(exp));
        check({tag, "_v"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        // reset held for 2 cycles with operations offered
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            step();
            check("rst_out", 32'({out_valid, ovf, cout, s}), 32'd0);
        end

        // directed vectors on consecutive cycles, expected {ovf, cout, s}
        directed("d0", 4'b0110, 4'b1100, 1'b0, 6'b0_1_0010);
        directed("d1", 4'b1110, 4'b1000, 1'b0, 6'b1_1_0110);
        directed("d2", 4'b0111, 4'b1110, 1'b0, 6'b0_1_0101);
        directed("d3", 4'b0010, 4'b1001, 1'b0, 6'b0_0_1011);
        directed("c0", 4'b1111, 4'b0000, 1'b1, 6'b0_1_0000);
        directed("c1", 4'b0111, 4'b0000, 1'b1, 6'b1_0_1000);
        directed("c2", 4'b1111, 4'b1111, 1'b1, 6'b0_1_1111);

        // hold with changing operands
        directed("h0", 4'b0011, 4'b0100, 1'b0, 6'b0_0_0111);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            step();
            check("hold_s", 32'({ovf, cout, s}), 32'(6'b0_0_0111));
            check("hold_v", 32'(out_valid), 32'd0);
        end

        // reset coinciding with an operation discards it
        drive(1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0);
        step();
        check("rst_mid", 32'({out_valid, ovf, cout, s}), 32'd0);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        step();
        check("rst_mid_nopulse", 32'(out_valid), 32'd0);

        // exhaustive sweep, back to back
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            drive(1'b0, 1'b1, v[3:0], v[7:4], v[8]);
        end

        // random traffic with gaps and occasional resets
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        end

        drive(1'b0, 1'b0, '0, '0, 1'b0);
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
